// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-step shift controller with valid/ready request and response ports
module shift_sequencer #(
    parameter int COUNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [7:0]         req_data,
    input  logic               req_cin,
    input  logic [2:0]         req_mode,
    input  logic [COUNT_W-1:0] req_count,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [7:0]         resp_data,
    output logic               resp_cout,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         data_reg;
    logic               carry_reg;
    logic [2:0]         mode_reg;
    logic [COUNT_W-1:0] remaining;

    logic               accept;
    logic               new_bit;
    logic [7:0]         step_out;
    logic               step_cout;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign busy       = (state != IDLE);
    assign resp_data  = data_reg;
    assign resp_cout  = carry_reg;
    assign accept     = req_valid & req_ready;

    // Single-step shift unit: the incoming bit is either a copy of an edge bit or the gated carry
    always_comb begin
        new_bit = mode_reg[1] ? (mode_reg[0] ? data_reg[7] : data_reg[0])
                              : (carry_reg & mode_reg[0]);
        if (mode_reg[2]) begin
            step_out  = {new_bit, data_reg[7:1]};
            step_cout = data_reg[0];
        end else begin
            step_out  = {data_reg[6:0], new_bit};
            step_cout = data_reg[7];
        end
    end

    // State register; reset wins over any handshake in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: zero count skips RUN, last step lands in DONE
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (req_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (remaining == COUNT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on accept, then one step per RUN cycle; registers hold in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= 8'h00;
            carry_reg <= 1'b0;
            mode_reg  <= 3'b000;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_reg  <= req_data;
                        carry_reg <= req_cin;
                        mode_reg  <= req_mode;
                        remaining <= req_count;
                    end
                end
                RUN: begin
                    data_reg  <= step_out;
                    carry_reg <= step_cout;
                    remaining <= remaining - COUNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic       req_cin;
    logic [2:0] req_mode;
    logic [3:0] req_count;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_cout;
    logic       busy;

    int total;
    int bad;

    shift_sequencer #(.COUNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_cin    (req_cin),
        .req_mode   (req_mode),
        .req_count  (req_count),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_cout  (resp_cout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       c;
        logic [2:0] m;
        logic [3:0] n;
        logic [7:0] ed;
        logic       ec;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte after n steps for modes whose result does not depend on the carry
    function automatic int shape(input int d, input int m, input int n);
        int s;
        int k;
        case (m)
            0: return (d << n) & 255;
            4: return d >> n;
            2: begin
                if (n >= 8) return (d & 1) ? 255 : 0;
                return ((d << n) | (((d & 1) != 0) ? ((1 << n) - 1) : 0)) & 255;
            end
            3: begin
                k = n % 8;
                return ((d << k) | (d >> (8 - k))) & 255;
            end
            6: begin
                k = n % 8;
                return ((d >> k) | (d << (8 - k))) & 255;
            end
            default: begin
                s = (d > 127) ? d - 256 : d;
                return (s >>> n) & 255;
            end
        endcase
    endfunction

    // Reference: 9-bit rotate for through-carry modes, closed forms otherwise
    task automatic model(input int d, input int c, input int m, input int n,
                         output int od, output int oc);
        int v;
        int k;
        if (m == 1 || m == 5) begin
            v = (c << 8) | d;
            k = n % 9;
            if (m == 1) v = ((v << k) | (v >> (9 - k))) & 511;
            else        v = ((v >> k) | (v << (9 - k))) & 511;
            od = v & 255;
            oc = v >> 8;
        end else begin
            od = shape(d, m, n);
            if (n == 0) begin
                oc = c;
            end else begin
                v  = shape(d, m, n - 1);
                oc = (m >= 4) ? (v & 1) : ((v >> 7) & 1);
            end
        end
    endtask

    task automatic wait_resp(input bit scramble, output int lat);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            if (scramble) begin
                req_valid = 1'($urandom);
                req_data  = 8'($urandom);
                req_cin   = 1'($urandom);
                req_mode  = 3'($urandom);
                req_count = 4'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        req_valid = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] d, input logic c, input logic [2:0] m,
                          input logic [3:0] n, input logic [7:0] ed, input logic ec,
                          input int hold);
        int lat;
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_data  = d;
        req_cin   = c;
        req_mode  = m;
        req_count = n;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(1'b1, lat);
        check("latency", lat, (n == 0) ? 1 : n + 1);
        check("resp_data", resp_data, ed);
        check("resp_cout", resp_cout, ec);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", resp_valid, 1);
            check("hold_data", {resp_cout, resp_data}, {ec, ed});
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("resp_dropped", resp_valid, 0);
        check("ready_after", req_ready, 1);
    endtask

    vec_t vecs[8];

    initial begin
        int lat;
        int seen;
        int ed;
        int ec;
        logic [7:0] rd;
        logic       rc;
        logic [2:0] rm;
        logic [3:0] rn;

        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_data   = 8'h00;
        req_cin    = 1'b0;
        req_mode   = 3'b000;
        req_count  = 4'd0;
        resp_ready = 1'b0;

        vecs[0] = '{8'h96, 1'b1, 3'b000, 4'd3,  8'hB0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 3'b101, 4'd1,  8'h00, 1'b1};
        vecs[2] = '{8'h01, 1'b0, 3'b101, 4'd9,  8'h01, 1'b0};
        vecs[3] = '{8'h80, 1'b0, 3'b111, 4'd3,  8'hF0, 1'b0};
        vecs[4] = '{8'h5A, 1'b1, 3'b111, 4'd0,  8'h5A, 1'b1};
        vecs[5] = '{8'h81, 1'b0, 3'b011, 4'd15, 8'hC0, 1'b0};
        vecs[6] = '{8'h01, 1'b1, 3'b001, 4'd8,  8'h80, 1'b1};
        vecs[7] = '{8'h03, 1'b0, 3'b110, 4'd1,  8'h81, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_cout", resp_cout, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].d, vecs[i].c, vecs[i].m, vecs[i].n, vecs[i].ed, vecs[i].ec, 1);
        end

        // Backpressure with a second request waiting on req_valid
        req_valid = 1'b1;
        req_data  = 8'h96;
        req_cin   = 1'b1;
        req_mode  = 3'b000;
        req_count = 4'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp(1'b0, lat);
        check("bp_latency", lat, 4);
        req_valid = 1'b1;
        req_data  = 8'h01;
        req_cin   = 1'b0;
        req_mode  = 3'b101;
        req_count = 4'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", resp_valid, 1);
            check("bp_data", resp_data, 8'hB0);
            check("bp_cout", resp_cout, 0);
            check("bp_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp_after_ready", req_ready, 1);
        check("bp_after_valid", resp_valid, 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp_second_accepted", busy, 1);
        check("bp_second_not_ready", req_ready, 0);
        wait_resp(1'b0, lat);
        check("bp2_latency", lat, 2);
        check("bp2_data", resp_data, 8'h00);
        check("bp2_cout", resp_cout, 1);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Reset during the third RUN cycle of a long operation
        req_valid = 1'b1;
        req_data  = 8'h5A;
        req_cin   = 1'b1;
        req_mode  = 3'b011;
        req_count = 4'd10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_data", resp_data, 0);
        check("mid_rst_cout", resp_cout, 0);
        check("mid_rst_ready", req_ready, 1);
        seen = 0;
        resp_ready = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        resp_ready = 1'b0;
        check("no_stale_resp", seen, 0);

        // Random operations against the reference model
        for (int i = 0; i < 60; i++) begin
            rd = 8'($urandom);
            rc = 1'($urandom);
            rm = 3'($urandom);
            rn = 4'($urandom);
            model(int'(rd), int'(rc), int'(rm), int'(rn), ed, ec);
            run_op(rd, rc, rm, rn, 8'(ed), 1'(ec), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
